fruit_spawn_scheduler: RTL

Game-level controller that sequences the fruit datapath: decides when a new fruit is launched, which fruit slot receives it, and what randomized launch position and velocity it gets. Tracks per-slot occupancy, counts cut fruits (score), derives the difficulty level that shortens the spawn interval, and counts missed fruits to end the game. Sits between the keyboard/slash-detection logic and an array of fruit motion instances, all clocked by the frame clock.

---
 rtl/fruit_pkg.sv | 34 +++
 rtl/lfsr16.sv | 29 ++
 rtl/fruit_spawn_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit game controller: FSM state,
// screen geometry, LFSR feedback taps and launch-parameter ranges.
package fruit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int X_MAX    = 639;
  localparam int X_CENTER = 320;
  localparam int Y_MAX    = 479;

  // Fibonacci taps 16,14,13,11 expressed as zero-based bit positions.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int LAUNCH_X_BASE = 64;
  localparam int LAUNCH_VX_MIN = 1;
  localparam int LAUNCH_VY_MIN = 8;
  localparam int START_DELAY   = 16;
  localparam int MAX_LEVEL     = 15;

  // Frames between launches for a given difficulty level, clamped from below.
  function automatic logic [7:0] spawn_interval(input logic [3:0] level,
                                                input int base_iv,
                                                input int min_iv);
    int iv;
    iv = base_iv - 4 * int'(level);
    if (iv < min_iv) iv = min_iv;
    return 8'(iv);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used as the launch-randomisation source.
module lfsr16
  import fruit_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = en_i ? {state_q[14:0], ^(state_q & LFSR_TAPS)} : state_q;
  end

  // NOTE: clocked state is always written with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/fruit_spawn_scheduler.sv
// Game-level controller: schedules fruit launches into free slots, tracks
// occupancy, score, difficulty level and misses, and ends the game.
module fruit_spawn_scheduler
  import fruit_pkg::*;
#(
  parameter int          NUM_SLOTS     = 4,
  parameter int          BASE_INTERVAL = 90,
  parameter int          MIN_INTERVAL  = 20,
  parameter int          MAX_MISSES    = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [NUM_SLOTS-1:0] cut,
  input  logic [NUM_SLOTS-1:0] offscreen,
  output logic [NUM_SLOTS-1:0] launch,
  output logic [9:0]           launch_x,
  output logic [9:0]           launch_vx,
  output logic [9:0]           launch_vy,
  output logic [NUM_SLOTS-1:0] active,
  output logic [7:0]           score,
  output logic [3:0]           level,
  output logic [1:0]           misses,
  output logic                 game_over
);

  state_e state_q, state_d;

  logic [7:0]           countdown_q, countdown_d;
  logic [NUM_SLOTS-1:0] launch_q, launch_d;
  logic [9:0]           launch_x_q, launch_x_d;
  logic [9:0]           launch_vx_q, launch_vx_d;
  logic [9:0]           launch_vy_q, launch_vy_d;
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [7:0]           score_q, score_d;
  logic [3:0]           level_q, level_d;
  logic [1:0]           misses_q, misses_d;

  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic        run_play;
  logic        enter_play;
  logic        game_over_o;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (frame_clk),
    .rst    (Reset),
    .en_i   (1'b1),
    .state_o(lfsr)
  );

  assign lfsr_unused = ^lfsr[15:14];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_PLAY;
      ST_PLAY: if (int'(misses_q) >= MAX_MISSES) state_d = ST_OVER;
      ST_OVER: if (start) state_d = ST_PLAY;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    game_over_o = (state_q == ST_OVER);
    run_play    = (state_q == ST_PLAY) && (state_d == ST_PLAY);
    enter_play  = (state_q != ST_PLAY) && (state_d == ST_PLAY);
  end

  // ---------------- Datapath ----------------
  logic [NUM_SLOTS-1:0] free_slots, slot_sel, cut_hit, miss_hit;
  logic [7:0]           cut_cnt, miss_cnt;
  logic [8:0]           score_sum;
  logic [7:0]           miss_sum;
  logic                 fire;
  logic [9:0]           x_new, vx_mag;

  always_comb begin
    free_slots = ~active_q;
    slot_sel   = free_slots & (~free_slots + NUM_SLOTS'(1));
    // Cut takes priority: a slot both cut and lost in one frame is a score.
    cut_hit    = cut & active_q;
    miss_hit   = offscreen & active_q & ~cut;

    cut_cnt  = 8'd0;
    miss_cnt = 8'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cut_cnt  = cut_cnt + 8'(cut_hit[i]);
      miss_cnt = miss_cnt + 8'(miss_hit[i]);
    end
    score_sum = {1'b0, score_q} + {1'b0, cut_cnt};
    miss_sum  = {6'd0, misses_q} + miss_cnt;

    fire   = run_play && (countdown_q <= 8'd1) && (|free_slots);
    x_new  = 10'(LAUNCH_X_BASE) + {1'b0, lfsr[8:0]};
    vx_mag = 10'(LAUNCH_VX_MIN) + {8'd0, lfsr[10:9]};
  end

  always_comb begin
    countdown_d = countdown_q;
    launch_d    = '0;
    launch_x_d  = launch_x_q;
    launch_vx_d = launch_vx_q;
    launch_vy_d = launch_vy_q;
    active_d    = active_q;
    score_d     = score_q;
    level_d     = level_q;
    misses_d    = misses_q;

    if (enter_play) begin
      countdown_d = 8'(START_DELAY);
      active_d    = '0;
      score_d     = 8'd0;
      level_d     = 4'd0;
      misses_d    = 2'd0;
    end else if (state_q == ST_PLAY && !run_play) begin
      active_d = '0;
    end else if (run_play) begin
      active_d = active_q & ~(cut_hit | miss_hit);
      score_d  = score_sum[8] ? 8'd255 : score_sum[7:0];
      level_d  = (score_d[7:6] != 2'b00) ? 4'(MAX_LEVEL) : score_d[5:2];
      misses_d = (miss_sum > 8'd3) ? 2'd3 : miss_sum[1:0];

      // Selection looks at registered occupancy, so a slot freed this frame
      // only becomes a launch target on the following frame.
      if (fire) begin
        launch_d    = slot_sel;
        active_d    = active_d | slot_sel;
        countdown_d = spawn_interval(level_q, BASE_INTERVAL, MIN_INTERVAL);
        launch_x_d  = x_new;
        launch_vx_d = (x_new < 10'(X_CENTER)) ? vx_mag : -vx_mag;
        launch_vy_d = -(10'(LAUNCH_VY_MIN) + {7'd0, lfsr[13:11]});
      end else if (countdown_q != 8'd0) begin
        countdown_d = countdown_q - 8'd1;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      countdown_q <= 8'd0;
      launch_q    <= '0;
      launch_x_q  <= 10'd0;
      launch_vx_q <= 10'd0;
      launch_vy_q <= 10'd0;
      active_q    <= '0;
      score_q     <= 8'd0;
      level_q     <= 4'd0;
      misses_q    <= 2'd0;
    end else begin
      countdown_q <= countdown_d;
      launch_q    <= launch_d;
      launch_x_q  <= launch_x_d;
      launch_vx_q <= launch_vx_d;
      launch_vy_q <= launch_vy_d;
      active_q    <= active_d;
      score_q     <= score_d;
      level_q     <= level_d;
      misses_q    <= misses_d;
    end
  end

  assign launch    = launch_q;
  assign launch_x  = launch_x_q;
  assign launch_vx = launch_vx_q;
  assign launch_vy = launch_vy_q;
  assign active    = active_q;
  assign score     = score_q;
  assign level     = level_q;
  assign misses    = misses_q;
  assign game_over = game_over_o;

endmodule
